pkt_capture: RTL and testbench

PKT_CAPTURE -- requirements
Module: pkt_capture

---
 rtl/pkt_capture.sv | 201 ++++++++++++++++++++
 tb/tb_pkt_capture.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_capture.sv
// rtl/pkt_capture.sv - Avalon-ST packet capture into a FIFO with write-controller handoff
//
// Accepts Avalon-ST packets, writes admitted words to a downstream FIFO and
// hands a descriptor (byte length + status flags) to a write controller.
//
// Ports
//   clk, reset             sole clock; synchronous active-high reset
//   st_data/valid/sop/eop  Avalon-ST beat, first byte in st_data[31:24]
//   st_empty               unused bytes in the eop beat
//   st_ready               beat accepted when st_valid && st_ready
//   fifo_data, wrreq       registered FIFO write (one cycle after the beat)
//   usedw, almost_full     FIFO fill status used for admission
//   wr_ctrl                one-cycle descriptor-valid pulse
//   pkt_begin/end, control descriptor; control[0]=oversize, control[1]=truncated
//   wr_ctrl_rdy            write controller idle/done; rising edge releases us
//   drop_count             saturating count of packets refused or cut short

module pkt_capture #(
    parameter int MAX_WORDS  = 256,
    parameter int FIFO_DEPTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [1:0]  st_empty,
    output logic        st_ready,
    output logic [31:0] fifo_data,
    output logic        wrreq,
    input  logic [8:0]  usedw,
    input  logic        almost_full,
    output logic        wr_ctrl,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] control,
    input  logic        wr_ctrl_rdy,
    output logic [15:0] drop_count
);

    // A packet is admitted only if a worst-case (MAX_WORDS) packet still fits.
    localparam int THRESH = FIFO_DEPTH - 1 - MAX_WORDS;
    localparam int CW     = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DROP,
        COMMIT,
        WAIT_RDY
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        tail_q, tail_d;        // rest of the stream must be discarded after handoff
    logic        rdy_prev_q;
    logic [31:0] fifo_data_q, fifo_data_d;
    logic        wrreq_q, wrreq_d;
    logic [31:0] pkt_end_q, pkt_end_d;
    logic [31:0] control_q, control_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        drop_inc;
    logic        accept;
    logic        room;

    assign st_ready   = !reset && (state_q == IDLE || state_q == CAPTURE || state_q == DROP);
    assign accept     = st_valid && st_ready;
    assign room       = !almost_full && (THRESH >= 0) && (int'(usedw) <= THRESH);

    assign fifo_data  = fifo_data_q;
    assign wrreq      = wrreq_q;
    assign wr_ctrl    = (state_q == COMMIT);
    assign pkt_begin  = '0;
    assign pkt_end    = pkt_end_q;
    assign control    = control_q;
    assign drop_count = drop_count_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tail_d       = tail_q;
        fifo_data_d  = fifo_data_q;
        wrreq_d      = 1'b0;
        pkt_end_d    = pkt_end_q;
        control_d    = control_q;
        drop_count_d = drop_count_q;
        drop_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                // Non-sop beats here are stray tails; swallow them without counting.
                if (accept && st_sop) begin
                    if (room) begin
                        wrreq_d     = 1'b1;
                        fifo_data_d = st_data;
                        cnt_d       = CW'(1);
                        if (st_eop) begin
                            pkt_end_d = 32'd4 - 32'(st_empty);
                            control_d = 32'd0;
                            tail_d    = 1'b0;
                            state_d   = COMMIT;
                        end else if (MAX_WORDS == 1) begin
                            pkt_end_d = 32'(MAX_WORDS) << 2;
                            control_d = 32'd1;
                            tail_d    = 1'b1;
                            state_d   = COMMIT;
                        end else begin
                            state_d   = CAPTURE;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!st_eop) begin
                            state_d = DROP;
                        end
                    end
                end
            end

            CAPTURE: begin
                if (accept) begin
                    if (st_sop) begin
                        // New packet before eop: close the current one as truncated
                        // and throw the newcomer away.
                        pkt_end_d = 32'(cnt_q) << 2;
                        control_d = 32'd2;
                        drop_inc  = 1'b1;
                        tail_d    = !st_eop;
                        state_d   = COMMIT;
                    end else begin
                        wrreq_d     = 1'b1;
                        fifo_data_d = st_data;
                        cnt_d       = cnt_q + CW'(1);
                        if (st_eop) begin
                            pkt_end_d = ((32'(cnt_q) + 32'd1) << 2) - 32'(st_empty);
                            control_d = 32'd0;
                            tail_d    = 1'b0;
                            state_d   = COMMIT;
                        end else if (32'(cnt_q) + 32'd1 == 32'(MAX_WORDS)) begin
                            // Full and still no eop: hand off now, discard the rest later.
                            pkt_end_d = 32'(MAX_WORDS) << 2;
                            control_d = 32'd1;
                            tail_d    = 1'b1;
                            state_d   = COMMIT;
                        end
                    end
                end
            end

            DROP: begin
                if (accept && st_eop) begin
                    state_d = IDLE;
                end
            end

            COMMIT: begin
                state_d = WAIT_RDY;
            end

            WAIT_RDY: begin
                if (wr_ctrl_rdy && !rdy_prev_q) begin
                    state_d = tail_q ? DROP : IDLE;
                    tail_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (drop_inc && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tail_q       <= 1'b0;
            rdy_prev_q   <= 1'b0;
            fifo_data_q  <= '0;
            wrreq_q      <= 1'b0;
            pkt_end_q    <= '0;
            control_q    <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tail_q       <= tail_d;
            rdy_prev_q   <= wr_ctrl_rdy;
            fifo_data_q  <= fifo_data_d;
            wrreq_q      <= wrreq_d;
            pkt_end_q    <= pkt_end_d;
            control_q    <= control_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_pkt_capture.sv
// tb/tb_pkt_capture.sv - randomized self-checking bench for pkt_capture

module tb_pkt_capture;

    localparam int MAX_WORDS  = 256;
    localparam int FIFO_DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] st_data;
    logic        st_valid, st_sop, st_eop;
    logic [1:0]  st_empty;
    logic        st_ready;
    logic [31:0] fifo_data;
    logic        wrreq;
    logic [8:0]  usedw;
    logic        almost_full;
    logic        wr_ctrl;
    logic [31:0] pkt_begin, pkt_end, control;
    logic        wr_ctrl_rdy;
    logic [15:0] drop_count;

    pkt_capture #(.MAX_WORDS(MAX_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
        .st_empty(st_empty), .st_ready(st_ready),
        .fifo_data(fifo_data), .wrreq(wrreq),
        .usedw(usedw), .almost_full(almost_full),
        .wr_ctrl(wr_ctrl), .pkt_begin(pkt_begin), .pkt_end(pkt_end), .control(control),
        .wr_ctrl_rdy(wr_ctrl_rdy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    typedef struct {
        logic [31:0] pe;
        logic [31:0] ctl;
    } commit_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_wq[$];
    commit_t     exp_cq[$];
    int          exp_drops = 0;
    commit_t     exp_last;
    int          waiting = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor plus write-controller model: rdy drops on each wr_ctrl
    // and comes back after a random delay, which is the only way out of waiting.
    initial begin
        int      delay;
        int      leak;
        commit_t c;
        wr_ctrl_rdy = 1'b1;
        delay = 0;
        leak  = 0;
        forever begin
            @(negedge clk);
            if (wrreq) begin
                if (exp_wq.size() == 0) check_eq("wr_unexpected", 32'(wrreq), 32'd0);
                else check_eq("wr_data", fifo_data, exp_wq.pop_front());
            end
            if (wr_ctrl) begin
                check_eq("commit_after_writes", 32'(exp_wq.size()), 32'd0);
                if (exp_cq.size() == 0) begin
                    check_eq("ctrl_unexpected", 32'(wr_ctrl), 32'd0);
                end else begin
                    c = exp_cq.pop_front();
                    check_eq("pkt_end", pkt_end, c.pe);
                    check_eq("control", control, c.ctl);
                    check_eq("pkt_begin", pkt_begin, 32'd0);
                end
                wr_ctrl_rdy = 1'b0;
                delay   = $urandom_range(1, 6);
                leak    = st_ready ? 1 : 0;
                waiting = 1;
            end else if (waiting == 1) begin
                if (st_ready) leak++;
                delay--;
                if (delay == 0) begin
                    wr_ctrl_rdy = 1'b1;
                    waiting = 2;
                end
            end else if (waiting == 2) begin
                check_eq("ready_held_low", 32'(leak), 32'd0);
                check_eq("ready_after_rdy", 32'(st_ready), 32'd1);
                waiting = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic drive_beats(input beat_t bq[$], input int abort_after);
        int acc;
        int guard;
        acc = 0;
        for (int i = 0; i < bq.size(); i++) begin
            if (abort_after >= 0 && acc == abort_after) break;
            if ($urandom_range(0, 3) == 0) begin
                st_valid = 1'b0;
                @(negedge clk);
            end
            st_data  = bq[i].d;
            st_sop   = bq[i].sop;
            st_eop   = bq[i].eop;
            st_empty = bq[i].empty;
            st_valid = 1'b1;
            #1;
            guard = 0;
            while (!st_ready && guard < 500) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 500) begin
                check_eq("beat_timeout", 32'(st_ready), 32'd1);
                st_valid = 1'b0;
                return;
            end
            @(negedge clk);
            acc++;
        end
        st_valid = 1'b0;
    endtask

    task automatic quiesce();
        int guard;
        guard = 0;
        while ((exp_wq.size() != 0 || exp_cq.size() != 0 || waiting != 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            check_eq("quiesce_timeout", 32'(exp_wq.size() + exp_cq.size()), 32'd0);
            exp_wq.delete();
            exp_cq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // n: words of a normal packet; e: st_empty on eop; k>0: a new sop arrives
    // as beat k, followed by m beats ending in eop; junk: stray non-sop beats first.
    task automatic run_pkt(input int n, input int e, input int k, input int m,
                           input int uw, input int af, input int junk);
        beat_t       bq[$];
        beat_t       b;
        logic [31:0] words[$];
        int          first_len;
        bit          admit;
        commit_t     c;
        for (int j = 0; j < junk; j++) begin
            b.d = $urandom; b.sop = 1'b0;
            b.eop = 1'($urandom_range(0, 1)); b.empty = 2'($urandom_range(0, 3));
            bq.push_back(b);
        end
        first_len = (k > 0) ? k : n;
        for (int i = 0; i < first_len; i++) begin
            b.d   = $urandom;
            b.sop = (i == 0);
            b.eop = (k == 0) && (i == n - 1);
            b.empty = b.eop ? 2'(e) : 2'($urandom_range(0, 3));
            bq.push_back(b);
            words.push_back(b.d);
        end
        if (k > 0) begin
            for (int i = 0; i < m; i++) begin
                b.d = $urandom; b.sop = (i == 0); b.eop = (i == m - 1);
                b.empty = 2'($urandom_range(0, 3));
                bq.push_back(b);
            end
        end

        admit = (af == 0) && (uw <= FIFO_DEPTH - 1 - MAX_WORDS);
        if (!admit) begin
            exp_drops++;
        end else begin
            if ((k > 0 && k >= MAX_WORDS) || (k == 0 && n > MAX_WORDS)) begin
                for (int i = 0; i < MAX_WORDS; i++) exp_wq.push_back(words[i]);
                c.pe = 32'(MAX_WORDS * 4); c.ctl = 32'd1;
            end else if (k > 0) begin
                for (int i = 0; i < k; i++) exp_wq.push_back(words[i]);
                c.pe = 32'(k * 4); c.ctl = 32'd2;
                exp_drops++;
            end else begin
                for (int i = 0; i < n; i++) exp_wq.push_back(words[i]);
                c.pe = 32'(n * 4 - e); c.ctl = 32'd0;
            end
            exp_cq.push_back(c);
            exp_last = c;
        end

        usedw       = 9'(uw);
        almost_full = 1'(af);
        drive_beats(bq, -1);
        quiesce();
        check_eq("drop_count", 32'(drop_count), 32'(exp_drops));
        check_eq("pkt_end_stable", pkt_end, exp_last.pe);
        check_eq("control_stable", control, exp_last.ctl);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_st_ready"}, 32'(st_ready), 32'd0);
        check_eq({tag, "_wrreq"}, 32'(wrreq), 32'd0);
        check_eq({tag, "_wr_ctrl"}, 32'(wr_ctrl), 32'd0);
        check_eq({tag, "_fifo_data"}, fifo_data, 32'd0);
        check_eq({tag, "_pkt_begin"}, pkt_begin, 32'd0);
        check_eq({tag, "_pkt_end"}, pkt_end, 32'd0);
        check_eq({tag, "_control"}, control, 32'd0);
        check_eq({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    endtask

    // n, e, k, m, usedw, almost_full, junk
    int dir_tab[14][7] = '{
        '{ 64, 2,   0, 0,   0, 0, 0},
        '{ 20, 1,   0, 0, 300, 0, 0},
        '{ 10, 0,   0, 0,   0, 0, 1},
        '{300, 1,   0, 0,   0, 0, 0},
        '{  0, 0,  10, 5,   0, 0, 0},
        '{  1, 3,   0, 0,   0, 0, 0},
        '{  5, 0,   0, 0, 255, 0, 0},
        '{  5, 0,   0, 0, 256, 0, 0},
        '{  5, 1,   0, 0,   0, 1, 2},
        '{  1, 2,   0, 0, 400, 0, 0},
        '{256, 0,   0, 0,   0, 0, 0},
        '{257, 3,   0, 0,   0, 0, 0},
        '{  0, 0, 256, 1,   0, 0, 0},
        '{  0, 0,   3, 1,   0, 0, 0}
    };

    initial begin
        beat_t bq[$];
        beat_t b;
        int    n, k, m, uw, cls;

        reset = 1'b1;
        st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_empty = '0;
        usedw = '0; almost_full = 1'b0;
        exp_last.pe = '0; exp_last.ctl = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", 32'(st_ready), 32'd1);

        for (int t = 0; t < 14; t++) begin
            run_pkt(dir_tab[t][0], dir_tab[t][1], dir_tab[t][2], dir_tab[t][3],
                    dir_tab[t][4], dir_tab[t][5], dir_tab[t][6]);
        end

        for (int t = 0; t < 16; t++) begin
            cls = $urandom_range(0, 3);
            case (cls)
                0: n = $urandom_range(1, 8);
                1: n = $urandom_range(9, 80);
                2: n = $urandom_range(250, 262);
                default: n = $urandom_range(263, 300);
            endcase
            k = 0;
            m = 0;
            if ($urandom_range(0, 4) == 0) begin
                k = ($urandom_range(0, 3) == 0) ? $urandom_range(254, 258) : $urandom_range(1, 30);
                m = $urandom_range(1, 5);
            end
            uw = ($urandom_range(0, 3) == 0) ? $urandom_range(256, 511) : $urandom_range(0, 255);
            run_pkt(n, $urandom_range(0, 3), k, m, uw,
                    ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 2));
        end

        // Reset in the middle of a 64-word packet, right after its 20th beat.
        usedw = '0; almost_full = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b.d = $urandom; b.sop = (i == 0); b.eop = (i == 63); b.empty = 2'd0;
            bq.push_back(b);
            if (i < 20) exp_wq.push_back(b.d);
        end
        drive_beats(bq, 20);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midpkt_reset");
        check_eq("midpkt_writes_done", 32'(exp_wq.size()), 32'd0);
        exp_wq.delete();
        exp_drops = 0;
        exp_last.pe = '0; exp_last.ctl = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_midpkt_reset", 32'(st_ready), 32'd1);
        repeat (10) @(negedge clk);
        run_pkt(12, 1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
